chip8_fetch: RTL and testbench
==============================

# chip8_fetch

Instruction fetch unit for the CHIP-8 core. Reads the two big-endian bytes at the program counter from the shared byte-wide 4 KiB memory, assembles the 16-bit opcode, and presents it to the `cpu` decode/execute block over a valid/ready handshake. It owns the fetch PC: it advances by 2 on each accepted instruction, or loads a PC redirect supplied by the CPU for jumps, skips, call and return.

## Interface
Parameters:
- `ADDR_W`, 12: memory address width; all PC arithmetic is modulo 2^ADDR_W.
- `RESET_PC`, 'h200: fetch PC after reset.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `mem_req`, out, 1: read request. Held high until granted.
- `mem_addr`, out, ADDR_W: byte address. Stable while `mem_req` is high.
- `mem_gnt`, in, 1: arbiter grant. A read is accepted in the cycle where `mem_req` and `mem_gnt` are both high.
- `mem_rvalid`, in, 1: read data valid, exactly 1 cycle after the accepting cycle.
- `mem_rdata`, in, 8: read byte.
- `instr_valid`, out, 1: `instr` and `instr_pc` are valid.
- `instr`, out, 16: opcode, {byte[pc], byte[pc+1]}.
- `instr_pc`, out, ADDR_W: address of `instr`.
- `instr_ready`, in, 1: CPU accepts the instruction.
- `redirect_valid`, in, 1: load a new fetch PC.
- `redirect_pc`, in, ADDR_W: new fetch PC.
- `fault`, out, 1: misaligned fetch. Sticky.

## Operation
- **FSM states:** REQ_HI, WAIT_HI, REQ_LO, WAIT_LO, HOLD, DRAIN, FAULT.
- **REQ_HI:**
  - `mem_req`=1, `mem_addr`=pc.
  - On grant, go to WAIT_HI.
- **WAIT_HI:**
  - On `mem_rvalid`, latch the high byte and go to REQ_LO.
- **REQ_LO:**
  - `mem_req`=1, `mem_addr`=pc+1 (mod 2^ADDR_W). 0xFFF wraps to 0x000.
  - On grant, go to WAIT_LO.
- **WAIT_LO:**
  - On `mem_rvalid`, latch the low byte and go to HOLD.
- **HOLD:**
  - `instr_valid`=1; `instr` and `instr_pc` are held stable.
  - When `instr_ready`=1, the handshake completes. The next pc is `redirect_pc` if `redirect_valid`=1, otherwise pc+2 (mod 2^ADDR_W). Then go to REQ_HI.
- **Redirect outside HOLD:**
  - In REQ_HI or REQ_LO with no grant in that cycle: load pc and go to REQ_HI.
  - In a REQ state with grant in the same cycle, or in WAIT_*: a response is outstanding. Load pc and go to DRAIN.
  - DRAIN discards the next `mem_rvalid`, then goes to REQ_HI.
  - A redirect received while in DRAIN updates pc only.
- **Stray responses:** `mem_rvalid` in REQ_*, HOLD or FAULT is ignored.
- **Priority:** redirect over pc+2. `instr_ready` is ignored outside HOLD.
- **Reset values:**
  - state REQ_HI, pc=RESET_PC.
  - `mem_req`=0, `mem_addr`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fault`=0.
  - `mem_req` rises in the first cycle after `rst` deasserts.
- **Reset mid-fetch:** abandons the fetch immediately. A response landing after reset arrives in REQ_HI and is ignored.

## Timing
- **Latency with `mem_gnt` tied high:** REQ_HI, WAIT_HI, REQ_LO, WAIT_LO, then HOLD. `instr_valid` rises 4 cycles after entering REQ_HI.
- **Throughput:** with `instr_ready` tied high, one instruction per 5 cycles.
- **Grant stalls:** each cycle of `mem_gnt` low in a REQ state adds 1 cycle.
- **Redirect penalty:**
  - Redirect at handshake: new `instr_valid` 5 cycles after the handshake cycle.
  - Redirect with a response outstanding: adds 1 DRAIN cycle.
- **Handshake and state updates:** `instr_valid` never depends combinationally on `instr_ready`. All outputs are registered.

## Configuration
- Macro: `CHIP8_FETCH_ALIGN_CHECK_EN`.
- **Defined:** entering REQ_HI with pc[0]=1 goes to FAULT instead.
  - No memory request is issued.
  - `instr_valid`=0 and `fault`=1.
  - A redirect in FAULT clears `fault` and restarts at REQ_HI with the new pc. The new pc is checked again.
  - `rst` also clears `fault`.
- **Not defined:**
  - Odd PCs are fetched normally.
  - FAULT state is not built.
  - `fault` is tied 0.

## Structure
- **`chip8_pkg`:**
  - `CHIP8_ADDR_W`=12.
  - `CHIP8_RESET_PC`='h200.
  - `CHIP8_INSTR_W`=16.
  - The fetch-state enum type.
- **Sub-modules:** none. This is a single module with one FSM, the pc register and a 16-bit assembly register.

## Test plan
- **Reset and first fetch:** memory holds 0x200=0x12, 0x201=0x34, `mem_gnt`=1 → reads at 0x200 then 0x201; `instr`=0x1234, `instr_pc`=0x200 with `instr_valid` 4 cycles after REQ_HI.
- **Back-to-back:** `instr_ready`=1 continuously → `instr_pc` sequence 0x200, 0x202, 0x204 at 5-cycle spacing.
- **Backpressure:** hold `instr_ready`=0 for 10 cycles in HOLD → `instr` stable, no `mem_req`; release → next fetch at 0x202.
- **Redirect:**
  - At handshake with `redirect_pc`=0x300 → next `instr_pc`=0x300.
  - Redirect to 0x400 during WAIT_LO → the outstanding byte is discarded; next instruction is from 0x400.
- **Wrap:** redirect to 0xFFE then accept → next fetch reads 0x000/0x001.
  - Macro off: redirect to 0xFFF → reads 0xFFF then 0x000.
- **Arbiter stall and fault:**
  - `mem_gnt` low for 3 cycles in REQ_LO → `mem_addr` held at 0x201; latency is 7.
  - Macro on: redirect to 0x201 → `fault`=1, no request; redirect to 0x202 → `fault`=0 and fetch resumes.
  - Async `rst` pulse in WAIT_HI → outputs zero immediately; fetch restarts at 0x200.

Source files
------------

// File: rtl/chip8_pkg.sv
// -----------------------------------------------------------------------------
// chip8_pkg
//
// Shared constants and types for the CHIP-8 core.
//   CHIP8_ADDR_W   : byte address width of the shared 4 KiB memory
//   CHIP8_RESET_PC : program entry point after reset
//   CHIP8_INSTR_W  : opcode width
//   fetch_state_e  : state encoding of the instruction fetch FSM
// -----------------------------------------------------------------------------
package chip8_pkg;

  localparam int CHIP8_ADDR_W   = 12;
  localparam int CHIP8_RESET_PC = 'h200;
  localparam int CHIP8_INSTR_W  = 16;

  typedef enum logic [2:0] {
    FETCH_REQ_HI  = 3'd0,
    FETCH_WAIT_HI = 3'd1,
    FETCH_REQ_LO  = 3'd2,
    FETCH_WAIT_LO = 3'd3,
    FETCH_HOLD    = 3'd4,
    FETCH_DRAIN   = 3'd5,
    FETCH_FAULT   = 3'd6
  } fetch_state_e;

  // True for the states that drive a memory read request.
  function automatic logic is_req_state(fetch_state_e s);
    return (s == FETCH_REQ_HI) || (s == FETCH_REQ_LO);
  endfunction

endpackage

// File: rtl/chip8_fetch.sv
// -----------------------------------------------------------------------------
// chip8_fetch
//
// Instruction fetch unit. Reads the two big-endian opcode bytes at the fetch
// PC from the shared byte-wide memory, assembles the 16-bit opcode and offers
// it to the CPU over a valid/ready handshake. Owns the fetch PC: +2 on every
// accepted instruction, or a CPU-supplied redirect (jump/skip/call/return).
//
// Optional feature (compile-time macro CHIP8_FETCH_ALIGN_CHECK_EN):
//   when defined, an odd fetch PC parks the unit in FAULT with `fault` high
//   until a redirect supplies a new PC; when undefined odd PCs are fetched
//   normally and `fault` is tied low.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_req/mem_addr    read request and byte address (held until granted)
//   mem_gnt             arbiter grant (accept = mem_req & mem_gnt)
//   mem_rvalid/rdata    read byte, one cycle after the accepting cycle
//   instr_valid/instr   opcode {byte[pc], byte[pc+1]} offered to the CPU
//   instr_pc            address of instr
//   instr_ready         CPU accepts the instruction
//   redirect_valid/pc   load a new fetch PC
//   fault               sticky misaligned-fetch flag
//
// All outputs are registered: the output process decodes the *next* state
// and the registers capture it, so outputs line up with the state register.
// -----------------------------------------------------------------------------
module chip8_fetch
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = CHIP8_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CHIP8_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [7:0]               mem_rdata,
  output logic                     instr_valid,
  output logic [CHIP8_INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     fault
);

  fetch_state_e state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;

  logic                     mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0]        mem_addr_reg, mem_addr_next;
  logic                     instr_valid_reg, instr_valid_next;
  logic [CHIP8_INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]        instr_pc_reg;

  // A read is accepted only when our registered request meets the grant.
  // This keeps the first post-reset cycle (request still low) from being
  // mistaken for an accepted read even if the grant is tied high.
  logic accept;
  assign accept = mem_req_reg & mem_gnt;

  // ---------------------------------------------------------------------------
  // State register plus registered outputs / datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= FETCH_REQ_HI;
      pc_reg          <= RESET_PC;
      mem_req_reg     <= 1'b0;
      mem_addr_reg    <= '0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      mem_req_reg     <= mem_req_next;
      mem_addr_reg    <= mem_addr_next;
      instr_valid_reg <= instr_valid_next;
      // Bytes are latched only on the transitions that consume them, so a
      // response killed by a redirect never reaches the opcode register.
      if (state_reg == FETCH_WAIT_HI && state_next == FETCH_REQ_LO) begin
        instr_reg[15:8] <= mem_rdata;
      end
      if (state_reg == FETCH_WAIT_LO && state_next == FETCH_HOLD) begin
        instr_reg[7:0] <= mem_rdata;
        instr_pc_reg   <= pc_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-PC logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;

    case (state_reg)
      FETCH_REQ_HI: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          // An accepted read still owes us a response; it must be dropped.
          state_next = accept ? FETCH_DRAIN : FETCH_REQ_HI;
        end else if (accept) begin
          state_next = FETCH_WAIT_HI;
        end
      end

      FETCH_WAIT_HI: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          // The response normally lands in this very cycle; if it did, it is
          // simply not latched and nothing is left to drain.
          state_next = mem_rvalid ? FETCH_REQ_HI : FETCH_DRAIN;
        end else if (mem_rvalid) begin
          state_next = FETCH_REQ_LO;
        end
      end

      FETCH_REQ_LO: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = accept ? FETCH_DRAIN : FETCH_REQ_HI;
        end else if (accept) begin
          state_next = FETCH_WAIT_LO;
        end
      end

      FETCH_WAIT_LO: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = mem_rvalid ? FETCH_REQ_HI : FETCH_DRAIN;
        end else if (mem_rvalid) begin
          state_next = FETCH_HOLD;
        end
      end

      FETCH_HOLD: begin
        if (instr_ready) begin
          pc_next    = redirect_valid ? redirect_pc : pc_reg + ADDR_W'(2);
          state_next = FETCH_REQ_HI;
        end
      end

      FETCH_DRAIN: begin
        if (redirect_valid) begin
          pc_next = redirect_pc;
        end
        if (mem_rvalid) begin
          state_next = FETCH_REQ_HI;
        end
      end

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
      FETCH_FAULT: begin
        if (redirect_valid) begin
          pc_next    = redirect_pc;
          state_next = FETCH_REQ_HI;
        end
      end
`endif

      default: begin
        state_next = FETCH_REQ_HI;
      end
    endcase

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    // Every path into REQ_HI funnels through here, so an odd PC from any
    // source (redirect, drain exit, fault exit) is caught before a request.
    if (state_next == FETCH_REQ_HI && pc_next[0]) begin
      state_next = FETCH_FAULT;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Output decode of the next state (captured by the register process)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_next     = is_req_state(state_next);
    mem_addr_next    = mem_addr_reg;
    instr_valid_next = (state_next == FETCH_HOLD);
    if (state_next == FETCH_REQ_HI) begin
      mem_addr_next = pc_next;
    end else if (state_next == FETCH_REQ_LO) begin
      mem_addr_next = pc_next + ADDR_W'(1);
    end
  end

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
  logic fault_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= (state_next == FETCH_FAULT);
    end
  end

  assign fault = fault_reg;
`else
  assign fault = 1'b0;
`endif

  assign mem_req     = mem_req_reg;
  assign mem_addr    = mem_addr_reg;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_chip8_fetch.sv
// -----------------------------------------------------------------------------
// tb_chip8_fetch
//
// Directed bench for chip8_fetch. A behavioural memory answers every accepted
// read one cycle later. Expected instructions are pushed into a scoreboard
// queue by the stimulus; a monitor pops and compares on every handshake.
// Cycle-level checks (latency, stalls, reset, fault) are made inline.
// Honours CHIP8_FETCH_ALIGN_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_chip8_fetch;

  typedef struct packed {
    logic [11:0] pc;
    logic [15:0] op;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic        instr_valid;
  logic [15:0] instr;
  logic [11:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic        fault;

  logic [7:0]  mem [4096];
  exp_t        sb_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  chip8_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Memory responder: data exactly one cycle after the accepting cycle.
  // Deliberately not reset, so an in-flight response can land after rst.
  always @(posedge clk) begin
    mem_rvalid <= mem_req & mem_gnt;
    mem_rdata  <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got pc %0h op %0h expected none", instr_pc, instr);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn pc=%03h op=%04h (expect pc=%03h op=%04h)", instr_pc, instr, e.pc, e.op);
        check("sb_instr_pc", 32'(instr_pc), 32'(e.pc));
        check("sb_instr", 32'(instr), 32'(e.op));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!instr_valid && k < 30) begin
      step(1);
      k++;
    end
    check(name, 32'(instr_valid), 32'd1);
  endtask

  // One-cycle accept, optionally with a redirect riding on the handshake.
  task automatic accept(input logic redir, input logic [11:0] rpc);
    instr_ready    = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    step(1);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
    mem[12'h200] = 8'h12; mem[12'h201] = 8'h34;
    mem[12'h202] = 8'h56; mem[12'h203] = 8'h78;
    mem[12'h204] = 8'h9A; mem[12'h205] = 8'hBC;
    mem[12'h300] = 8'hA2; mem[12'h301] = 8'h22;
    mem[12'h302] = 8'h33; mem[12'h303] = 8'h44;
    mem[12'h400] = 8'h6A; mem[12'h401] = 8'h0F;
    mem[12'hFFE] = 8'hDE; mem[12'hFFF] = 8'hAD;
    mem[12'h000] = 8'h00; mem[12'h001] = 8'hE0;

    // ---- reset values ----
    step(2);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // ---- first fetch: latency 4 from REQ_HI ----
    sb_q.push_back('{pc: 12'h200, op: 16'h1234});
    rst = 1'b0;
    step(1);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr_hi", 32'(mem_addr), 32'h200);
    step(2);
    check("first_addr_lo", 32'(mem_addr), 32'h201);
    step(1);
    check("first_valid_early", 32'(instr_valid), 32'd0);
    step(1);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", 32'(instr), 32'h1234);

    // ---- backpressure: 10 cycles held, no memory traffic ----
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("hold_stable", {14'd0, mem_req, instr_valid, instr}, {14'd0, 1'b0, 1'b1, 16'h1234});
    end

    // ---- back-to-back with ready high: 5-cycle spacing ----
    sb_q.push_back('{pc: 12'h202, op: 16'h5678});
    sb_q.push_back('{pc: 12'h204, op: 16'h9ABC});
    instr_ready = 1'b1;
    step(1);
    check("b2b_next_addr", 32'(mem_addr), 32'h202);
    check("b2b_valid_drop", 32'(instr_valid), 32'd0);
    step(3);
    check("b2b_valid_early", 32'(instr_valid), 32'd0);
    step(1);
    check("b2b_pc_202", {instr_valid, 19'd0, instr_pc}, {1'b1, 19'd0, 12'h202});
    step(5);
    check("b2b_pc_204", {instr_valid, 19'd0, instr_pc}, {1'b1, 19'd0, 12'h204});

    // ---- redirect at handshake to 0x300 ----
    sb_q.push_back('{pc: 12'h300, op: 16'hA222});
    redirect_valid = 1'b1;
    redirect_pc    = 12'h300;
    step(1);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    check("redir_addr", 32'(mem_addr), 32'h300);
    step(4);
    check("redir_latency", 32'(instr_valid), 32'd1);

    // ---- redirect to 0x400 while the low byte of 0x302 is in flight ----
    sb_q.push_back('{pc: 12'h400, op: 16'h6A0F});
    accept(1'b0, 12'h000);
    k = 0;
    while (!(mem_req && mem_addr == 12'h303) && k < 20) begin
      step(1);
      k++;
    end
    check("reach_req_lo_303", 32'(mem_addr), 32'h303);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 12'h400;
    step(1);
    redirect_valid = 1'b0;
    wait_valid("drain_valid");
    check("drain_instr_pc", 32'(instr_pc), 32'h400);

    // ---- wrap: 0xFFE then 0x000 ----
    sb_q.push_back('{pc: 12'hFFE, op: 16'hDEAD});
    accept(1'b1, 12'hFFE);
    check("wrap_addr_ffe", 32'(mem_addr), 32'hFFE);
    wait_valid("wrap_ffe_valid");
    sb_q.push_back('{pc: 12'h000, op: 16'h00E0});
    accept(1'b0, 12'h000);
    check("wrap_addr_000", 32'(mem_addr), 32'h000);
    wait_valid("wrap_000_valid");

`ifdef CHIP8_FETCH_ALIGN_CHECK_EN
    // ---- misaligned redirect faults, good redirect recovers ----
    accept(1'b1, 12'h201);
    check("fault_set", 32'(fault), 32'd1);
    check("fault_no_req", 32'(mem_req), 32'd0);
    step(3);
    check("fault_sticky", {fault, mem_req, instr_valid}, 3'b100);
    sb_q.push_back('{pc: 12'h202, op: 16'h5678});
    redirect_valid = 1'b1;
    redirect_pc    = 12'h202;
    step(1);
    redirect_valid = 1'b0;
    check("fault_clear", 32'(fault), 32'd0);
    check("fault_resume", {mem_req, 19'd0, mem_addr}, {1'b1, 19'd0, 12'h202});
    wait_valid("fault_resume_valid");
`else
    // ---- odd PC fetched normally, wrapping 0xFFF -> 0x000 ----
    sb_q.push_back('{pc: 12'hFFF, op: 16'hAD00});
    accept(1'b1, 12'hFFF);
    check("odd_addr_fff", 32'(mem_addr), 32'hFFF);
    step(2);
    check("odd_addr_wrap", {mem_req, 19'd0, mem_addr}, {1'b1, 19'd0, 12'h000});
    wait_valid("odd_valid");
    check("odd_fault_low", 32'(fault), 32'd0);
`endif

    // ---- async reset in WAIT_HI ----
    accept(1'b0, 12'h000);
    step(1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_zero", {mem_req, instr_valid, fault, instr, 1'b0, mem_addr}, 32'd0);
    check("arst_instr_pc", 32'(instr_pc), 32'd0);
    #2;
    rst = 1'b0;

    // ---- restart at 0x200 with 3 grant-low cycles in REQ_LO ----
    sb_q.push_back('{pc: 12'h200, op: 16'h1234});
    step(1);
    check("restart_addr", {mem_req, 19'd0, mem_addr}, {1'b1, 19'd0, 12'h200});
    step(2);
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_addr_held", {mem_req, 19'd0, mem_addr}, {1'b1, 19'd0, 12'h201});
    end
    mem_gnt = 1'b1;
    step(1);
    check("stall_valid_early", 32'(instr_valid), 32'd0);
    step(1);
    check("stall_latency7", 32'(instr_valid), 32'd1);
    accept(1'b0, 12'h000);
    step(1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
